// File: rtl/cpu_types.sv
// cpu_types: shared fetch-sequencer state encoding and next-PC select codes
//   fseq_state_t  : sequencer states IDLE, RUN, DRAIN, HALTED
//   PC_*          : PCSrc values for the fetch-stage next-PC mux
//   redir_pcsrc() : maps a redirect source to a PCSrc, falling back to sequential on the illegal code 0
package cpu_types;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} fseq_state_t;
   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_JR  = 2'd1;
   localparam logic [1:0] PC_J   = 2'd2;
   localparam logic [1:0] PC_BR  = 2'd3;
   function automatic logic [1:0] redir_pcsrc(input logic [1:0] s);
      return (s == PC_JR || s == PC_J || s == PC_BR) ? s : PC_SEQ;
   endfunction
endpackage

// File: rtl/perf_counter.sv
// perf_counter: enable-driven wrapping event counter with asynchronous clear
//   CLK   in  clock
//   RST   in  asynchronous active-high clear
//   en    in  count this cycle
//   count out current value, wraps modulo 2^CNT_W
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge CLK or posedge RST)
      if (RST) count <= '0;
      else if (en) count <= count + CNT_W'(1);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage PC/imem-request sequencer with redirect, halt and perf counters
//   CLK, RST                      clock, asynchronous active-high reset
//   ihit, imemREN                 instruction-memory handshake
//   dstall, halt                  decode backpressure and halt detect
//   redir_valid/src, redir_ack    execute-stage PC redirect request/ack
//   pcen, PCSrc                   PC load enable and next-PC select
//   fd_en, fd_flush               fetch/decode latch load and bubble insert
//   halted                        sequencer parked in HALTED
//   perf_wait, perf_redir         imem wait cycles and applied redirects
module fetch_sequencer
   import cpu_types::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   output logic             imemREN,
   input  logic             dstall,
   input  logic             halt,
   input  logic             redir_valid,
   input  logic [1:0]       redir_src,
   output logic             redir_ack,
   output logic             pcen,
   output logic [1:0]       PCSrc,
   output logic             fd_en,
   output logic             fd_flush,
   output logic             halted,
   output logic [CNT_W-1:0] perf_wait,
   output logic [CNT_W-1:0] perf_redir
);
   fseq_state_t state, next;
   logic take;

   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= IDLE;
      else state <= next;

   assign imemREN = state == RUN || state == DRAIN;
   assign halted  = state == HALTED;
   // a redirect is only applied once the in-flight fetch returns, or at once when parked
   assign take    = (imemREN && ihit && redir_valid) || (halted && redir_valid);

   always_comb begin
      next      = state;
      pcen      = 1'b0;
      PCSrc     = PC_SEQ;
      fd_en     = 1'b0;
      fd_flush  = 1'b0;
      redir_ack = 1'b0;
      case (state)
         IDLE:   next = RUN;
         RUN:
            if (ihit) begin
               if (!redir_valid && halt) next = HALTED;
               else if (!redir_valid && !dstall) begin
                  pcen  = 1'b1;
                  fd_en = 1'b1;
               end
            end else if (halt && !redir_valid) next = DRAIN;
         DRAIN:  if (ihit) next = redir_valid ? RUN : HALTED;
         HALTED: if (redir_valid) next = RUN;
         default: next = IDLE;
      endcase
      if (take) begin
         pcen      = 1'b1;
         PCSrc     = redir_pcsrc(redir_src);
         redir_ack = 1'b1;
         fd_flush  = 1'b1;
      end
   end

   perf_counter #(.CNT_W(CNT_W)) u_wait (
      .CLK  (CLK),
      .RST  (RST),
      .en   (imemREN && !ihit),
      .count(perf_wait)
   );

   perf_counter #(.CNT_W(CNT_W)) u_redir (
      .CLK  (CLK),
      .RST  (RST),
      .en   (redir_ack),
      .count(perf_redir)
   );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;
   logic CLK = 1'b0;
   logic RST, ihit, dstall, halt, redir_valid;
   logic [1:0] redir_src;
   logic imemREN, redir_ack, pcen, fd_en, fd_flush, halted;
   logic [1:0] PCSrc;
   logic [31:0] perf_wait, perf_redir;

   int n_chk = 0;
   int n_fail = 0;

   // model: booting = first cycle after reset, draining = waiting for the last fetch before halting
   bit m_boot, m_drain, m_halt;
   logic [31:0] m_wait, m_redir;
   logic [7:0] e_out;
   logic [7:0] act;

   fetch_sequencer #(.CNT_W(32)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemREN(imemREN), .dstall(dstall), .halt(halt),
      .redir_valid(redir_valid), .redir_src(redir_src), .redir_ack(redir_ack), .pcen(pcen),
      .PCSrc(PCSrc), .fd_en(fd_en), .fd_flush(fd_flush), .halted(halted),
      .perf_wait(perf_wait), .perf_redir(perf_redir)
   );

   always #5 CLK = ~CLK;

   assign act = {imemREN, halted, pcen, PCSrc, fd_en, fd_flush, redir_ack};

   // {imemREN, halted, pcen, PCSrc, fd_en, fd_flush, redir_ack}
   function automatic logic [7:0] model_out();
      logic req, rd, adv;
      req = !m_boot && !m_halt;
      rd  = (req && ihit && redir_valid) || (m_halt && redir_valid);
      adv = req && ihit && !m_drain && !halt && !dstall && !rd;
      return {req, m_halt, rd | adv, rd ? redir_src : 2'b00, adv, rd, rd};
   endfunction

   task automatic model_step();
      logic req, rd;
      req = !m_boot && !m_halt;
      rd  = (req && ihit && redir_valid) || (m_halt && redir_valid);
      m_wait  = m_wait + 32'(req && !ihit);
      m_redir = m_redir + 32'(rd);
      if (m_boot) m_boot = 0;
      else if (rd) begin m_drain = 0; m_halt = 0; end
      else if (req && ihit && (m_drain || halt)) begin m_drain = 0; m_halt = 1; end
      else if (req && !ihit && halt && !redir_valid && !m_drain) m_drain = 1;
   endtask

   task automatic model_reset();
      m_boot = 1; m_drain = 0; m_halt = 0; m_wait = 0; m_redir = 0;
   endtask

   task automatic set_in(input logic ih, input logic ds, input logic hl, input logic rv, input logic [1:0] src);
      ihit = ih; dstall = ds; halt = hl; redir_valid = rv; redir_src = src;
   endtask

   task automatic settle();
      @(negedge CLK);
      e_out = model_out();
   endtask

   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      set_in(1, 1, 1, 1, 2'd3);
      RST = 1'b1;
      model_reset();
      #2;
      n_chk++;
      if (act !== 8'h00 || perf_wait !== 32'd0 || perf_redir !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_hold: outputs %b cnt %0d/%0d, required 00000000 cnt 0/0", act, perf_wait, perf_redir);
      end
      @(posedge CLK);
      @(posedge CLK);
      #1;
      set_in(0, 0, 0, 0, 2'd0);
      RST = 1'b0;
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 6; i++) begin
         set_in(1, 0, 0, 0, 2'd0);
         settle();
         n_chk++;
         if (act !== e_out || perf_wait !== m_wait) begin
            n_fail++;
            $display("FAIL sequential[%0d]: outputs %b wait %0d, required %b wait %0d", i, act, perf_wait, e_out, m_wait);
         end
         tick();
      end
   endtask

   task automatic test_wait_states();
      for (int i = 0; i < 5; i++) begin
         set_in(i >= 3, 0, 0, 0, 2'd0);
         settle();
         n_chk++;
         if (act !== e_out || perf_wait !== m_wait) begin
            n_fail++;
            $display("FAIL wait_states[%0d]: outputs %b wait %0d, required %b wait %0d", i, act, perf_wait, e_out, m_wait);
         end
         tick();
      end
   endtask

   task automatic test_redirect_pending();
      for (int i = 0; i < 4; i++) begin
         set_in(i >= 2, 0, 0, i < 3, 2'd3);
         settle();
         n_chk++;
         if (act !== e_out || perf_redir !== m_redir) begin
            n_fail++;
            $display("FAIL redirect_pending[%0d]: outputs %b redir %0d, required %b redir %0d", i, act, perf_redir, e_out, m_redir);
         end
         tick();
      end
   endtask

   task automatic test_halt_drain();
      // {ihit, dstall, halt, rv, src}
      logic [5:0] tbl [8] = '{6'b001000, 6'b000000, 6'b100000, 6'b100000,
                              6'b011000, 6'b000101, 6'b100000, 6'b110000};
      for (int i = 0; i < 8; i++) begin
         set_in(tbl[i][5], tbl[i][4], tbl[i][3], tbl[i][2], tbl[i][1:0]);
         settle();
         n_chk++;
         if (act !== e_out || {perf_wait, perf_redir} !== {m_wait, m_redir}) begin
            n_fail++;
            $display("FAIL halt_drain[%0d]: outputs %b cnt %0d/%0d, required %b cnt %0d/%0d",
                     i, act, perf_wait, perf_redir, e_out, m_wait, m_redir);
         end
         tick();
      end
   endtask

   task automatic test_halt_with_redirect();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, i == 0, i == 0, 2'd2);
         settle();
         n_chk++;
         if (act !== e_out || perf_redir !== m_redir) begin
            n_fail++;
            $display("FAIL halt_with_redirect[%0d]: outputs %b redir %0d, required %b redir %0d", i, act, perf_redir, e_out, m_redir);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic rv_h;
      logic [1:0] src_h;
      rv_h = 0;
      src_h = 2'd1;
      for (int i = 0; i < 400; i++) begin
         if (!rv_h && $urandom_range(0, 5) == 0) begin
            rv_h = 1;
            src_h = 2'($urandom_range(1, 3));
         end
         set_in($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, rv_h, src_h);
         settle();
         n_chk++;
         if (act !== e_out || {perf_wait, perf_redir} !== {m_wait, m_redir}) begin
            n_fail++;
            $display("FAIL random[%0d]: outputs %b cnt %0d/%0d, required %b cnt %0d/%0d",
                     i, act, perf_wait, perf_redir, e_out, m_wait, m_redir);
         end
         if (e_out[0]) rv_h = 0;
         tick();
      end
   endtask

   task automatic test_reset_mid_drain();
      test_reset();
      for (int i = 0; i < 7; i++) begin
         set_in(0, 0, i == 5, 0, 2'd0);
         settle();
         n_chk++;
         if (act !== e_out || perf_wait !== m_wait) begin
            n_fail++;
            $display("FAIL pre_drain[%0d]: outputs %b wait %0d, required %b wait %0d", i, act, perf_wait, e_out, m_wait);
         end
         if (i < 6) tick();
      end
      n_chk++;
      if (perf_wait !== 32'd5) begin
         n_fail++;
         $display("FAIL drain_wait_count: got %0d, required 5", perf_wait);
      end
      #1;
      RST = 1'b1;
      model_reset();
      #1;
      n_chk++;
      if (act !== 8'h00 || perf_wait !== 32'd0 || perf_redir !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_drain: outputs %b cnt %0d/%0d, required 00000000 cnt 0/0", act, perf_wait, perf_redir);
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1, 0, 0, 0, 2'd0);
         settle();
         n_chk++;
         if (act !== e_out || perf_wait !== m_wait) begin
            n_fail++;
            $display("FAIL restart[%0d]: outputs %b wait %0d, required %b wait %0d", i, act, perf_wait, e_out, m_wait);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait_states();
      test_redirect_pending();
      test_halt_drain();
      test_halt_with_redirect();
      test_random();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
